pc_gen: RTL
===========

# pc_gen

Parametrised fetch-address generator for the front end. It emits one aligned fetch group of `FETCH_WIDTH` instructions per accepted request to the icache, with a per-slot valid mask. It follows branch-predictor redirects, including the MIPS delay slot when the slot crosses a group boundary. It resolves exception and misprediction flushes and keeps branch/hit performance counters.

## Interface
- `ADDR_W`, 32, address width.
- `FETCH_WIDTH`, 4, instructions per group; power of two, 1..8.
- `RESET_PC`, 32'hbfc00000, boot address.
- `CNT_W`, 32, performance counter width.
- Derived: `OFF = clog2(FETCH_WIDTH)`; `SW = max(1, OFF)`; `GB = FETCH_WIDTH*4` (group bytes).

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: synchronous, active-low reset.
- `flush` in 1: pipeline flush.
- `flush_cause` in 1: 0 = exception, 1 = failed branch prediction.
- `epc` in ADDR_W: exception target.
- `branch_flag` in 1: branch resolved taken in EX.
- `npc_actual` in ADDR_W: resolved branch target.
- `ex_pc` in ADDR_W: PC of the branch in EX.
- `pred_taken` in 1: BPU predicts a taken branch in the current group.
- `pred_slot` in SW: slot index of the predicted branch.
- `pred_target` in ADDR_W: predicted target.
- `icache_ready` in 1: icache accepts this cycle.
- `ibuffer_full` in 1: instruction buffer full.
- `pc` out ADDR_W: current fetch PC (may be unaligned).
- `rreq_to_icache` out 1: fetch request.
- `fetch_mask` out FETCH_WIDTH: valid slots of the group.
- `branch_count` out CNT_W: resolved taken branches.
- `hit_count` out CNT_W: taken branches without misprediction flush.

## Operation
- FSM states:
  - BOOT: after reset, no request.
  - FETCH: normal fetch.
  - DSLOT: fetching the group that holds a delay slot.
- Register `tgt_q` (ADDR_W) holds a deferred predicted target.
- Group base is `base = pc & ~(GB-1)`.
- `accept = rreq_to_icache & icache_ready`.
- `rreq_to_icache = resetn & (state != BOOT) & ~flush & ~ibuffer_full` (combinational).
- Next `pc`, first match wins:
  1. `!resetn` → RESET_PC.
  2. `flush & cause==0` → epc.
  3. `flush & cause==1 & branch_flag` → npc_actual.
  4. `flush & cause==1 & !branch_flag` → ex_pc+8.
  5. `!accept` → pc (held).
  6. state DSLOT → tgt_q.
  7. `pred_taken & (pred_slot < FETCH_WIDTH-1)` → pred_target.
  8. `pred_taken & (pred_slot == FETCH_WIDTH-1)` → base+GB; latch `tgt_q <= pred_target`.
  9. otherwise → base+GB.
- State transitions:
  - BOOT→FETCH unconditionally on the first cycle out of reset.
  - Any flush → FETCH; tgt_q is discarded.
  - FETCH→DSLOT on case 8.
  - DSLOT→FETCH on accept.
- `fetch_mask` in FETCH:
  - Bit i is set iff `i >= pc[OFF+1:2]`.
  - If `pred_taken`, bits `i > pred_slot+1` are also cleared.
- `fetch_mask` in DSLOT: slot 0 only; pred_* inputs are ignored.
- `fetch_mask` in BOOT: 0.
- With FETCH_WIDTH=1, OFF=0: every predicted-taken branch takes the DSLOT path.
- Counters, evaluated each cycle when resetn=1:
  - `branch_count` increments when `branch_flag`.
  - `hit_count` increments when `branch_flag & !(flush & flush_cause)`.
  - Both wrap modulo 2^CNT_W.
- Arithmetic is modulo 2^ADDR_W; base+GB wraps from 0xFFFF_FFF0 to 0.

## Timing
- Reset values: pc = RESET_PC, state BOOT, tgt_q = 0, counters 0. rreq_to_icache = 0 and fetch_mask = 0 during reset and the first cycle after it.
- The first request is issued on the 2nd cycle after resetn rises, at RESET_PC.
- Flush takes effect the same cycle: request dropped. The new pc is presented the next cycle, with rreq high if ibuffer_full=0.
- Handshake: pc and fetch_mask stay stable while rreq=1 and icache_ready=0.
- ibuffer_full holds pc and suppresses rreq; there is no bubble on release.
- A flush during DSLOT overrides the deferred target.
- A flush while reset is asserted is ignored.
- Reset mid-DSLOT returns the block to BOOT.

## Structure
- Package `pc_gen_pkg` contains:
  - the state enum (BOOT/FETCH/DSLOT);
  - `FLUSH_EXC=0` and `FLUSH_BPU=1`;
  - the default `RESET_PC`.
- Sub-module `pc_perf_cnt` (parameter CNT_W): a generic wrapping counter with enable and synchronous clear, instantiated twice.

## Test plan
- Reset then release, FW=4, icache_ready=1: cycle 1 rreq=0; then pc 0xbfc00000, 0xbfc00010, 0xbfc00020 on successive cycles, mask 4'b1111.
- FW=4: `flush=1, cause=1, branch_flag=1, npc_actual=0x8000_0008` → next pc 0x80000008, mask 4'b1100, then pc 0x80000010.
- FW=4, pc=0xbfc00000, pred_taken, slot=3, target 0x9000_0000 → group 0xbfc00010 fetched with mask 4'b0001, then pc 0x90000000.
- FW=4, pc=0xbfc00000, pred_taken, slot=1, target 0x9000_0004 → mask 4'b0111, next pc 0x90000004.
- icache_ready low for 3 cycles with ibuffer_full pulsed high → pc and mask unchanged, rreq low only while full; a flush with cause=0 arriving during the stall → pc=epc next cycle.
- 5 branch_flag pulses, 2 of them with flush & cause=1 → branch_count=5, hit_count=3; CNT_W=4 with 17 pulses → branch_count=1.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-address generator.
//   pc_state_e       : fetch FSM states (boot, normal fetch, delay-slot group)
//   FLUSH_EXC/BPU    : flush_cause encodings
//   DEFAULT_RESET_PC : boot address used when no override is given
//   slot_bits()      : width of a slot index for a given fetch width
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DSLOT
  } pc_state_e;

  localparam logic FLUSH_EXC = 1'b0;
  localparam logic FLUSH_BPU = 1'b1;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc0_0000;

  // A single-slot group still needs a 1-bit slot index port.
  function automatic int unsigned slot_bits(input int unsigned fw);
    return (fw <= 1) ? 1 : $clog2(fw);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch request bus between pc_gen and the icache.
//   pc             : current fetch PC (may be unaligned within the group)
//   rreq_to_icache : fetch request
//   fetch_mask     : valid slots of the requested group
//   icache_ready   : icache accepts the request this cycle
// master = pc_gen side, slave = icache side.
interface pc_gen_if #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned FETCH_WIDTH = 4
);

  logic [ADDR_W-1:0]      pc;
  logic                   rreq_to_icache;
  logic [FETCH_WIDTH-1:0] fetch_mask;
  logic                   icache_ready;

  modport master (
    output pc,
    output rreq_to_icache,
    output fetch_mask,
    input  icache_ready
  );

  modport slave (
    input  pc,
    input  rreq_to_icache,
    input  fetch_mask,
    output icache_ready
  );

endinterface

// File: rtl/pc_perf_cnt.sv
// pc_perf_cnt: generic wrapping event counter.
//   clk   : clock
//   clr   : synchronous clear (wins over en)
//   en    : count one event this cycle
//   count : current value, wraps modulo 2^CNT_W
module pc_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator. Emits one aligned group of FETCH_WIDTH
// instructions per accepted request, follows predicted-taken branches
// (deferring the target by one group when the delay slot falls in the next
// group), resolves exception / misprediction flushes and counts branches.
//   clk, resetn            : clock, synchronous active-low reset
//   flush, flush_cause     : pipeline flush and its reason (exception / BPU)
//   epc                    : exception redirect target
//   branch_flag            : branch in EX resolved taken
//   npc_actual, ex_pc      : resolved target / PC of the branch in EX
//   pred_taken, pred_slot,
//   pred_target            : BPU prediction for the current group
//   ibuffer_full           : instruction buffer back-pressure
//   fetch_if (master)      : pc / rreq_to_icache / fetch_mask / icache_ready
//   branch_count, hit_count: performance counters
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned            ADDR_W      = 32,
  parameter int unsigned            FETCH_WIDTH = 4,
  parameter logic [ADDR_W-1:0]      RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned            CNT_W       = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           flush,
  input  logic                           flush_cause,
  input  logic [ADDR_W-1:0]              epc,
  input  logic                           branch_flag,
  input  logic [ADDR_W-1:0]              npc_actual,
  input  logic [ADDR_W-1:0]              ex_pc,
  input  logic                           pred_taken,
  input  logic [slot_bits(FETCH_WIDTH)-1:0] pred_slot,
  input  logic [ADDR_W-1:0]              pred_target,
  input  logic                           ibuffer_full,
  pc_gen_if.master                       fetch_if,
  output logic [CNT_W-1:0]               branch_count,
  output logic [CNT_W-1:0]               hit_count
);

  localparam int unsigned       OFF       = $clog2(FETCH_WIDTH);
  localparam int unsigned       SW        = slot_bits(FETCH_WIDTH);
  localparam int unsigned       GB        = FETCH_WIDTH * 4;
  localparam logic [ADDR_W-1:0] GB_A      = ADDR_W'(GB);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~(GB_A - ADDR_W'(1));

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  logic              rreq;
  logic              accept;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] next_grp;
  logic [SW-1:0]     start_slot;
  logic              pred_last;
  logic [FETCH_WIDTH-1:0] mask;

  // Slot of the first instruction to fetch within the group.
  generate
    if (OFF == 0) begin : g_single_slot
      assign start_slot = '0;
    end else begin : g_multi_slot
      assign start_slot = pc_q[OFF+1:2];
    end
  endgenerate

  assign base     = pc_q & BASE_MASK;
  assign next_grp = base + GB_A;

  // Predicted branch sits in the last slot: its delay slot lives in the next
  // group, so that group is fetched first and the target is deferred. With a
  // single-slot group every predicted branch lands here.
  assign pred_last = (32'(pred_slot) >= 32'(FETCH_WIDTH - 1));

  assign rreq   = resetn & (state_q != ST_BOOT) & ~flush & ~ibuffer_full;
  assign accept = rreq & fetch_if.icache_ready;

  // Valid-slot mask: from the (possibly unaligned) entry slot up to and
  // including the delay slot of a predicted-taken branch.
  always_comb begin
    mask = '0;
    if (resetn) begin
      case (state_q)
        ST_DSLOT: mask = FETCH_WIDTH'(1);
        ST_FETCH: begin
          for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            mask[i] = (i >= 32'(start_slot)) &&
                      !(pred_taken && (i > 32'(pred_slot) + 32'd1));
          end
        end
        default: mask = '0;
      endcase
    end
  end

  // Next pc / state / deferred target. Flush has priority over everything
  // except reset (handled in the register process).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    if (flush) begin
      state_d = ST_FETCH;
      tgt_d   = '0;
      if (flush_cause == FLUSH_EXC) begin
        pc_d = epc;
      end else if (branch_flag) begin
        pc_d = npc_actual;
      end else begin
        pc_d = ex_pc + ADDR_W'(8);
      end
    end else begin
      if (state_q == ST_BOOT) begin
        state_d = ST_FETCH;
      end
      if (accept) begin
        if (state_q == ST_DSLOT) begin
          pc_d    = tgt_q;
          state_d = ST_FETCH;
        end else if (pred_taken && !pred_last) begin
          pc_d = pred_target;
        end else if (pred_taken) begin
          pc_d    = next_grp;
          tgt_d   = pred_target;
          state_d = ST_DSLOT;
        end else begin
          pc_d = next_grp;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  assign fetch_if.pc             = pc_q;
  assign fetch_if.rreq_to_icache = rreq;
  assign fetch_if.fetch_mask     = mask;

  logic cnt_clr;
  logic branch_en;
  logic hit_en;

  assign cnt_clr   = ~resetn;
  assign branch_en = resetn & branch_flag;
  assign hit_en    = branch_en & ~(flush & (flush_cause == FLUSH_BPU));

  pc_perf_cnt #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (branch_en),
    .count (branch_count)
  );

  pc_perf_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (hit_en),
    .count (hit_count)
  );

endmodule
